// File: rtl/fdiv_iter.sv
// Iterative IEEE-754 divider: radix-2 restoring mantissa recurrence, one quotient
// bit per clock, round-to-nearest-even, valid/ready on both sides.
module fdiv_iter #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned BIAS  = 127
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [4:0]               flags
);

    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned NITER = MAN_W + 4;
    localparam int unsigned CNT_W = $clog2(NITER);
    localparam int unsigned EW    = EXP_W + 2;
    localparam int unsigned RW    = MAN_W + 2;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0]    EMAX     = EW'((1 << EXP_W) - 1);
    localparam logic [EW-1:0]    BIAS_E   = EW'(BIAS);
    localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [4:0] FL_NONE = 5'b00000;
    localparam logic [4:0] FL_INV  = 5'b10000;
    localparam logic [4:0] FL_DZ   = 5'b01000;
    localparam logic [4:0] FL_OVF  = 5'b00101;
    localparam logic [4:0] FL_UNF  = 5'b00011;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        ROUND,
        DONE
    } state_t;

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [RW-1:0]      rem_q,        rem_d;
    logic [RW-1:0]      dvs_q,        dvs_d;
    logic [NITER-1:0]   quo_q,        quo_d;
    logic               sign_q,       sign_d;
    logic [EW-1:0]      exp_q,        exp_d;
    logic               special_q,    special_d;
    logic [W-1:0]       spec_res_q,   spec_res_d;
    logic [4:0]         spec_flags_q, spec_flags_d;
    logic [W-1:0]       result_q,     result_d;
    logic [4:0]         flags_q,      flags_d;
    logic               out_valid_q,  out_valid_d;
    logic               in_ready_q,   in_ready_d;

    // Operand fields and classification
    logic               sa, sb, s_res;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               a_zero, a_inf, a_nan;
    logic               b_zero, b_inf, b_nan;
    logic               in_special;
    logic [W-1:0]       in_spec_res;
    logic [4:0]         in_spec_flags;

    always_comb begin
        sa     = a[W-1];
        sb     = b[W-1];
        ea     = a[W-2 -: EXP_W];
        eb     = b[W-2 -: EXP_W];
        fa     = a[MAN_W-1:0];
        fb     = b[MAN_W-1:0];
        s_res  = sa ^ sb;
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EXP_ONES) && (fa == '0);
        b_inf  = (eb == EXP_ONES) && (fb == '0);
        a_nan  = (ea == EXP_ONES) && (fa != '0);
        b_nan  = (eb == EXP_ONES) && (fb != '0);
        in_special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;

        in_spec_res   = {s_res, {(EXP_W+MAN_W){1'b0}}};
        in_spec_flags = FL_NONE;
        if (a_nan || b_nan) begin
            in_spec_res = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            in_spec_res   = QNAN;
            in_spec_flags = FL_INV;
        end else if (a_inf) begin
            in_spec_res = {s_res, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_zero) begin
            in_spec_res   = {s_res, EXP_ONES, {MAN_W{1'b0}}};
            in_spec_flags = FL_DZ;
        end
    end

    // Recurrence step
    logic               ge;
    logic [RW-1:0]      rem_sub;

    always_comb begin
        ge      = (rem_q >= dvs_q);
        rem_sub = ge ? (rem_q - dvs_q) : rem_q;
    end

    // Normalise, round to nearest even, range check
    logic               norm;
    logic [MAN_W-1:0]   kept;
    logic               guard, rnd, sticky, inc, carry;
    logic [MAN_W-1:0]   frac_r;
    logic [EW-1:0]      e_fin;
    logic               ovf, unf;
    logic [W-1:0]       rnd_res;
    logic [4:0]         rnd_flags;

    always_comb begin
        norm   = ~quo_q[NITER-1];
        kept   = norm ? quo_q[NITER-3 -: MAN_W] : quo_q[NITER-2 -: MAN_W];
        guard  = norm ? quo_q[1] : quo_q[2];
        rnd    = norm ? quo_q[0] : quo_q[1];
        sticky = (norm ? 1'b0 : quo_q[0]) | (|rem_q);
        inc    = guard & (rnd | sticky | kept[0]);
        {carry, frac_r} = {1'b0, kept} + {{MAN_W{1'b0}}, inc};
        e_fin  = exp_q - EW'(norm) + EW'(carry);
        // e_fin is two's complement; the sign bit separates underflow from huge values
        ovf    = ~e_fin[EW-1] && (e_fin >= EMAX);
        unf    = e_fin[EW-1] || (e_fin == '0);

        if (ovf) begin
            rnd_res   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
            rnd_flags = FL_OVF;
        end else if (unf) begin
            rnd_res   = {sign_q, {(EXP_W+MAN_W){1'b0}}};
            rnd_flags = FL_UNF;
        end else begin
            rnd_res   = {sign_q, e_fin[EXP_W-1:0], frac_r};
            rnd_flags = {4'b0000, guard | rnd | sticky};
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        dvs_d        = dvs_q;
        quo_d        = quo_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        special_d    = special_q;
        spec_res_d   = spec_res_q;
        spec_flags_d = spec_flags_q;
        result_d     = result_q;
        flags_d      = flags_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d       = s_res;
                    exp_d        = {2'b00, ea} - {2'b00, eb} + BIAS_E;
                    rem_d        = {1'b0, 1'b1, fa};
                    dvs_d        = {1'b0, 1'b1, fb};
                    quo_d        = '0;
                    cnt_d        = '0;
                    special_d    = in_special;
                    spec_res_d   = in_spec_res;
                    spec_flags_d = in_spec_flags;
                    // Specials pass through ROUND so they land in DONE one edge later
                    state_d      = in_special ? ROUND : DIV;
                end
            end
            DIV: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[NITER-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NITER - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                result_d = special_q ? spec_res_q   : rnd_res;
                flags_d  = special_q ? spec_flags_q : rnd_flags;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            quo_q        <= '0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            special_q    <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            dvs_q        <= dvs_d;
            quo_q        <= quo_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            special_q    <= special_d;
            spec_res_q   <= spec_res_d;
            spec_flags_q <= spec_flags_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Directed bench for fdiv_iter: single- and half-precision instances, hand-computed
// quotients, special operands, backpressure and mid-divide reset.
module tb_fdiv_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [4:0]  flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_result;
    logic [4:0]  h_flags;

    int n_tests = 0;
    int n_fail  = 0;

    fdiv_iter dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fdiv_iter #(.EXP_W(5), .MAN_W(10), .BIAS(15)) dut_h (
        .clk(clk), .rst_n(rst_n),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] want_res, input logic [4:0] want_flags,
                          input int want_lat);
        int lat;
        @(negedge clk);
        a = op_a;
        b = op_b;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, want_lat);
        check({tag, "_result"}, result, want_res);
        check({tag, "_flags"}, {27'b0, flags}, {27'b0, want_flags});
        @(posedge clk);
        #1;
        check({tag, "_released"}, {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int lat;
        int seen;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_flags", {27'b0, flags}, 32'h0);
        check("rst_h_ready", {31'b0, h_in_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;

        run_op("div6_2",    32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);
        run_op("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28);
        run_op("one_one",   32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 28);
        run_op("neg6_2",    32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 28);
        run_op("zero_zero", 32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10000, 1);
        run_op("neg1_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 5'b01000, 1);
        run_op("nan_in",    32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b00000, 1);
        run_op("inf_inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 1);
        run_op("inf_neg2",  32'h7F800000, 32'hC0000000, 32'hFF800000, 5'b00000, 1);
        run_op("two_inf",   32'h40000000, 32'h7F800000, 32'h00000000, 5'b00000, 1);
        run_op("overflow",  32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 28);
        run_op("underflow", 32'h00800000, 32'h4B000000, 32'h00000000, 5'b00011, 28);

        // Backpressure: result held in DONE, new operands ignored
        out_ready = 1'b0;
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", lat, 28);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_result", result, 32'h40400000);
            check("bp_flags", {27'b0, flags}, 32'h0);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_one_transfer", {31'b0, out_valid}, 32'd0);
        check("bp_ready_after", {31'b0, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("bp_no_extra_out", seen, 0);

        // Reset during DIV aborts the operation
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("rst_mid_no_out", seen, 0);
        run_op("post_rst",  32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);

        // Half precision: 1.0 / 2.0
        @(negedge clk);
        h_a = 16'h3C00; h_b = 16'h4000; h_in_valid = 1'b1;
        @(posedge clk);
        #1 h_in_valid = 1'b0;
        lat = 0;
        while (!h_out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("half_latency", lat, 15);
        check("half_result", {16'b0, h_result}, 32'h00003800);
        check("half_flags", {27'b0, h_flags}, 32'h0);
        @(posedge clk);
        #1;
        check("half_released", {30'b0, h_out_valid, h_in_ready}, 32'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
